// File: rtl/aes_cipher_top_if.sv
// Host-side bus of the AES-128 encryption core: load strobe, key/plaintext in,
// completion pulse and ciphertext out.
interface aes_cipher_top_if;
  logic         ld;
  logic [127:0] key;
  logic [127:0] text_in;
  logic         done;
  logic [127:0] text_out;

  modport master (output ld, key, text_in, input done, text_out);
  modport slave  (input ld, key, text_in, output done, text_out);
endinterface

// File: rtl/aes_cipher_top.sv
// Iterative AES-128 encryption, one round per clock, on-the-fly key expansion.
// Define AES_SBOX_LUT_EN for table S-boxes; otherwise S-boxes are computed arithmetically.
module aes_cipher_top (
  input  logic clk,
  input  logic rst,
  aes_cipher_top_if.slave bus
);
  typedef enum logic {IDLE, BUSY} fsm_e;

  fsm_e         fsm;
  logic [127:0] state, rkey, nkey, sb, sr, mc, nstate, text_out_r;
  logic [3:0]   rnd;
  logic         done_r;
  logic [7:0]   rcon;
  logic [31:0]  rot_w, sub_w, t_w;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

`ifdef AES_SBOX_LUT_EN
  // Rows indexed by the high nibble, byte within the row by the low nibble.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [127:0] row;
    case (x[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    return row[{~x[3:0], 3'b000} +: 8];
  endfunction
`else
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // Inverse through the GF(2^4) subfield: a^-1 = a^16 * N^-1, N = a^17 lies in
  // GF(2^4), whose inverse is N^14. Zero maps to zero naturally.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] a2, a4, a8, a16, n, n2, n4, n8, inv;
    a2  = gmul(x, x);
    a4  = gmul(a2, a2);
    a8  = gmul(a4, a4);
    a16 = gmul(a8, a8);
    n   = gmul(a16, x);
    n2  = gmul(n, n);
    n4  = gmul(n2, n2);
    n8  = gmul(n4, n4);
    inv = gmul(gmul(gmul(n2, n4), n8), a16);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
`endif

  always_comb begin
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign rot_w = {rkey[23:0], rkey[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_ksub
    assign sub_w[31-8*i -: 8] = sbox(rot_w[31-8*i -: 8]);
  end
  assign t_w               = sub_w ^ {rcon, 24'h0};
  assign nkey[127:96]      = rkey[127:96] ^ t_w;
  assign nkey[95:64]       = rkey[95:64]  ^ nkey[127:96];
  assign nkey[63:32]       = rkey[63:32]  ^ nkey[95:64];
  assign nkey[31:0]        = rkey[31:0]   ^ nkey[63:32];

  // Byte 4*c+r is s(r,c); row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sb[127-8*(4*c+r) -: 8] = sbox(state[127-8*(4*c+r) -: 8]);
      assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    end
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[127-32*c -: 8];
    assign a1 = sr[119-32*c -: 8];
    assign a2 = sr[111-32*c -: 8];
    assign a3 = sr[103-32*c -: 8];
    assign mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
  end

  assign nstate = ((rnd == 4'd10) ? sr : mc) ^ nkey;

  // A load overrides the round step, but a coinciding completion still
  // publishes its result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      state      <= '0;
      rkey       <= '0;
      rnd        <= '0;
      done_r     <= 1'b0;
      text_out_r <= '0;
    end else begin
      done_r <= 1'b0;
      if (fsm == BUSY) begin
        state <= nstate;
        rkey  <= nkey;
        rnd   <= rnd + 4'd1;
        if (rnd == 4'd10) begin
          text_out_r <= nstate;
          done_r     <= 1'b1;
          fsm        <= IDLE;
          rnd        <= 4'd0;
        end
      end
      if (bus.ld) begin
        state <= bus.text_in ^ bus.key;
        rkey  <= bus.key;
        rnd   <= 4'd1;
        fsm   <= BUSY;
      end
    end
  end

  assign bus.done     = done_r;
  assign bus.text_out = text_out_r;
endmodule

// File: tb/tb_aes_cipher_top.sv
// Bench for aes_cipher_top: known-answer vectors, timing corners and random
// vectors against a byte-level AES-128 reference.
module tb_aes_cipher_top;
  logic clk = 1'b0;
  logic rst;
  aes_cipher_top_if bus();
  aes_cipher_top dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb_ref [256];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a, y = b;
    while (y != 0) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: brute-force inverse, then the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00, s;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 1);
      sb_ref[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01, a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb_ref[tmp[23:16]], sb_ref[tmp[15:8]], sb_ref[tmp[7:0]], sb_ref[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8];
    for (int rd = 0; rd <= 10; rd++) begin
      if (rd > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sb_ref[s[i]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
        s = t;
        if (rd < 10)
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
            s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
            s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
            s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
          end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] ^= w[4*rd+c][31-8*r -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called 1ns after an edge; the next edge is the load edge.
  task automatic start(input logic [127:0] k, input logic [127:0] p);
    bus.ld = 1'b1; bus.key = k; bus.text_in = p;
    @(posedge clk); #1;
    bus.ld = 1'b0; bus.key = rand128(); bus.text_in = rand128();
  endtask

  task automatic wait_done(input string tag, input logic [127:0] exp);
    logic early = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
      early |= bus.done;
    end
    chk({tag, "_early_done"}, 128'(early), 128'd0);
    @(posedge clk); #1;
    chk({tag, "_done"}, 128'(bus.done), 128'd1);
    chk(tag, bus.text_out, exp);
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, 128'(bus.done), 128'd0);
    chk({tag, "_hold"}, bus.text_out, exp);
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    logic [127:0] kb, pb;
    logic seen;
    rst = 1'b1; bus.ld = 1'b0; bus.key = '0; bus.text_in = '0;
    build_sbox();
    chk("model_v1", aes_ref(K1, P1), C1);
    #12;
    chk("rst_done", 128'(bus.done), 128'd0);
    chk("rst_text", bus.text_out, 128'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    start(K1, P1); wait_done("fips_c1", C1);
    start(K2, P2); wait_done("fips_b", C2);
    start('0, '0); wait_done("zero", C0);

    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; seen |= bus.done; end
    chk("idle_done", 128'(seen), 128'd0);
    chk("idle_hold", bus.text_out, C0);

    // Reload B on the 4th edge after A's load.
    start(K1, P1);
    repeat (3) begin @(posedge clk); #1; end
    start(K2, P2); wait_done("reload_b", C2);

    // Load B on A's completion edge.
    kb = rand128(); pb = rand128();
    start('0, '0);
    seen = 1'b0;
    for (int c = 1; c < 10; c++) begin @(posedge clk); #1; seen |= bus.done; end
    chk("b2b_a_early", 128'(seen), 128'd0);
    start(kb, pb);
    chk("b2b_a_done", 128'(bus.done), 128'd1);
    chk("b2b_a_text", bus.text_out, C0);
    wait_done("b2b_b", aes_ref(kb, pb));

    // Reset at cycle 5 of an operation.
    start(K2, P2);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    chk("midrst_done", 128'(bus.done), 128'd0);
    chk("midrst_text", bus.text_out, 128'd0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (14) begin @(posedge clk); #1; seen |= bus.done; end
    chk("midrst_no_done", 128'(seen), 128'd0);
    chk("midrst_text_hold", bus.text_out, 128'd0);
    start(K1, P1); wait_done("after_rst", C1);

    for (int n = 0; n < 6; n++) begin
      kb = rand128(); pb = rand128();
      start(kb, pb); wait_done("random", aes_ref(kb, pb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
